// File: rtl/ring_pkg.sv
// Purpose : shared type codes, field widths and deframer FSM states for the ring router.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: TYPE_W/ADDR_W, frame type codes, rx_state_t, type_known().
package ring_pkg;

  localparam int TYPE_W = 3;
  localparam int ADDR_W = 4;

  localparam logic [TYPE_W-1:0] TYPE_TOKEN  = 3'b111;
  localparam logic [TYPE_W-1:0] TYPE_ACK    = 3'b000;
  localparam logic [TYPE_W-1:0] TYPE_NACK   = 3'b011;
  localparam logic [TYPE_W-1:0] TYPE_DATA_C = 3'b010;
  localparam logic [TYPE_W-1:0] TYPE_DATA_3 = 3'b001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_PAR,
    ST_PAY,
    ST_PAY_PAR
  } rx_state_t;

  // Codes 100, 101 and 110 are unassigned on the ring.
  function automatic logic type_known(input logic [TYPE_W-1:0] t);
    return (t == TYPE_TOKEN) || (t == TYPE_ACK) || (t == TYPE_NACK) ||
           (t == TYPE_DATA_C) || (t == TYPE_DATA_3);
  endfunction

endpackage

// File: rtl/ring_rx_deframer_if.sv
// Purpose : held-frame handshake between the rx deframer and the router control FSM.
// Latency : n/a (wires only).
// Backpr. : rx_has_data holds a frame until control pulses rc_ready.
// Modports: master = deframer (drives frame fields), slave = control (drives rc_ready).
interface ring_rx_if;
  import ring_pkg::*;

  logic              rc_ready;
  logic              rx_has_data;
  logic [TYPE_W-1:0] data_type;
  logic [ADDR_W-1:0] address;
  logic              bad_decode;
  logic [31:0]       rx_payload;
  logic [2:0]        rx_byte_cnt;
  logic              rx_overrun;

  modport master (
    input  rc_ready,
    output rx_has_data, data_type, address, bad_decode,
           rx_payload, rx_byte_cnt, rx_overrun
  );

  modport slave (
    output rc_ready,
    input  rx_has_data, data_type, address, bad_decode,
           rx_payload, rx_byte_cnt, rx_overrun
  );

endinterface

// File: rtl/rx_shift_parity.sv
// Purpose : 8-bit MSB-first shift register with running even-parity accumulator.
// Latency : dout/par reflect a shifted bit one edge after shift_en.
// Backpr. : none; clr has priority over shift_en.
// Ports   : Clk_R, Rst_n, clr, shift_en, din -> dout[7:0], par (XOR of bits since clr).
module rx_shift_parity (
  input  logic       Clk_R,
  input  logic       Rst_n,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       din,
  output logic [7:0] dout,
  output logic       par
);

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      dout <= '0;
      par  <= 1'b0;
    end else if (clr) begin
      dout <= '0;
      par  <= 1'b0;
    end else if (shift_en) begin
      dout <= {dout[6:0], din};
      par  <= par ^ din;
    end
  end

endmodule

// File: rtl/ring_rx_deframer.sv
// Purpose : deframes the serial ring input into type/address/payload for router control.
// Latency : rx_has_data rises one edge after the final parity bit is sampled (TOKEN: 9 cycles).
// Backpr. : frame held until rc_ready; a frame completing while one is held is dropped (rx_overrun).
// Ports   : Clk_R, Rst_n, Rx_In (idles high), rx (ring_rx_if.master).
// Config  : RX_PARITY_CHECK_EN defined -> parity errors set bad_decode; undefined -> parity ignored.
module ring_rx_deframer
  import ring_pkg::*;
#(
  parameter int DATA3_BYTES = 3,
  parameter int DATAC_BYTES = 4
) (
  input  logic      Clk_R,
  input  logic      Rst_n,
  input  logic      Rx_In,
  ring_rx_if.master rx
);

`ifdef RX_PARITY_CHECK_EN
  localparam logic PAR_CHK = 1'b1;
`else
  localparam logic PAR_CHK = 1'b0;
`endif

  rx_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [2:0] byte_idx;
  logic [2:0] len_q;
  logic [2:0] hdr_len;
  logic       sr_clr, sr_shift;
  logic       frame_done, done_q;
  logic [7:0] sr_dat;
  logic       sr_par;
  logic       par_err;

  // Shadow frame, built while bits arrive.
  logic [TYPE_W-1:0] type_sh;
  logic [ADDR_W-1:0] addr_sh;
  logic              bad_sh;
  logic [31:0]       pay_sh;

  // Held (output) frame.
  logic              has_q;
  logic [TYPE_W-1:0] type_q;
  logic [ADDR_W-1:0] addr_q;
  logic              bad_q;
  logic [31:0]       pay_q;
  logic [2:0]        cnt_q;
  logic              ovr_q;

  rx_shift_parity u_sr (
    .Clk_R    (Clk_R),
    .Rst_n    (Rst_n),
    .clr      (sr_clr),
    .shift_en (sr_shift),
    .din      (Rx_In),
    .dout     (sr_dat),
    .par      (sr_par)
  );

  // Valid only in the parity states: Rx_In is then the parity bit itself.
  assign par_err = PAR_CHK & (sr_par ^ Rx_In);

  // Payload length of the header currently sitting in the shift register.
  always_comb begin
    hdr_len = '0;
    case (sr_dat[6:4])
      TYPE_DATA_3: hdr_len = 3'(DATA3_BYTES);
      TYPE_DATA_C: hdr_len = 3'(DATAC_BYTES);
      default:     hdr_len = '0;
    endcase
  end

  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      bit_cnt <= '0;
    end else begin
      state_q <= state_d;
      // Counts bits within HDR/PAY; restarts whenever the state changes.
      if ((state_q == ST_HDR || state_q == ST_PAY) && state_d == state_q)
        bit_cnt <= bit_cnt + 3'd1;
      else
        bit_cnt <= '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_clr     = 1'b0;
    sr_shift   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!Rx_In) begin
          state_d = ST_HDR;
          sr_clr  = 1'b1;
        end
      end
      ST_HDR: begin
        sr_shift = 1'b1;
        if (bit_cnt == 3'd6) state_d = ST_HDR_PAR;
      end
      ST_HDR_PAR: begin
        sr_clr = 1'b1;
        if (hdr_len != 3'd0) begin
          state_d = ST_PAY;
        end else begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end
      end
      ST_PAY: begin
        sr_shift = 1'b1;
        if (bit_cnt == 3'd7) state_d = ST_PAY_PAR;
      end
      ST_PAY_PAR: begin
        sr_clr = 1'b1;
        if (byte_idx + 3'd1 == len_q) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
        end else begin
          state_d = ST_PAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow frame accumulation. Clearing on the start bit is safe even when it
  // coincides with done_q: the output copy below samples the pre-clear values.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      done_q   <= 1'b0;
      type_sh  <= '0;
      addr_sh  <= '0;
      bad_sh   <= 1'b0;
      pay_sh   <= '0;
      byte_idx <= '0;
      len_q    <= '0;
    end else begin
      done_q <= frame_done;
      case (state_q)
        ST_IDLE: begin
          if (!Rx_In) begin
            bad_sh   <= 1'b0;
            pay_sh   <= '0;
            byte_idx <= '0;
          end
        end
        ST_HDR_PAR: begin
          type_sh <= sr_dat[6:4];
          addr_sh <= sr_dat[3:0];
          len_q   <= hdr_len;
          bad_sh  <= ~type_known(sr_dat[6:4]) | par_err;
        end
        ST_PAY_PAR: begin
          // Byte n lands in [31-8n -: 8], i.e. bit offset (3-n)*8.
          pay_sh[{~byte_idx[1:0], 3'b000} +: 8] <= sr_dat;
          byte_idx <= byte_idx + 3'd1;
          bad_sh   <= bad_sh | par_err;
        end
        default: ;
      endcase
    end
  end

  // Hand-off to control, decided in the cycle after the last parity bit.
  always_ff @(posedge Clk_R or negedge Rst_n) begin
    if (!Rst_n) begin
      has_q  <= 1'b0;
      type_q <= '0;
      addr_q <= '0;
      bad_q  <= 1'b0;
      pay_q  <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!has_q || rx.rc_ready) begin
          has_q  <= 1'b1;
          type_q <= type_sh;
          addr_q <= addr_sh;
          bad_q  <= bad_sh;
          pay_q  <= pay_sh;
          cnt_q  <= byte_idx;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (rx.rc_ready) begin
        has_q <= 1'b0;
      end
    end
  end

  assign rx.rx_has_data = has_q;
  assign rx.data_type   = type_q;
  assign rx.address     = addr_q;
  assign rx.bad_decode  = bad_q;
  assign rx.rx_payload  = pay_q;
  assign rx.rx_byte_cnt = cnt_q;
  assign rx.rx_overrun  = ovr_q;

endmodule

// File: tb/tb_ring_rx_deframer.sv
// Purpose : self-checking bench for ring_rx_deframer (vector table, corner sequences, random frames).
// Latency : n/a.
// Backpr. : drives rc_ready through the ring_rx_if instance.
module tb_ring_rx_deframer;

`ifdef RX_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic Clk_R;
  logic Rst_n;
  logic Rx_In;
  ring_rx_if rx_if ();

  ring_rx_deframer #(
    .DATA3_BYTES (3),
    .DATAC_BYTES (4)
  ) dut (
    .Clk_R (Clk_R),
    .Rst_n (Rst_n),
    .Rx_In (Rx_In),
    .rx    (rx_if)
  );

  initial begin
    Clk_R = 1'b0;
    forever #5 Clk_R = ~Clk_R;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int ovr_seen = 0;

  always @(negedge Clk_R) if (rx_if.rx_overrun === 1'b1) ovr_seen++;

  // Reference model of the held frame.
  logic        m_has;
  logic [2:0]  m_type;
  logic [3:0]  m_addr;
  logic        m_bad;
  logic [31:0] m_pay;
  logic [2:0]  m_cnt;

  typedef struct {
    logic [2:0]  t;
    logic [3:0]  a;
    logic [31:0] pay;
    int          flip;   // -1 none, 0 header parity, n = parity of byte n
    logic [2:0]  e_type;
    logic [3:0]  e_addr;
    logic        e_bad;
    logic [31:0] e_pay;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] t);
    if (t == 3'b001) return 3;
    if (t == 3'b010) return 4;
    return 0;
  endfunction

  function automatic logic known(input logic [2:0] t);
    return !(t == 3'b100 || t == 3'b101 || t == 3'b110);
  endfunction

  task automatic drive_bit(input logic v);
    @(negedge Clk_R);
    Rx_In = v;
  endtask

  // Serialises one frame; returns right after the final parity bit is driven.
  task automatic drive_frame(input logic [2:0] t, input logic [3:0] a,
                             input logic [31:0] pay, input int flip);
    int n;
    logic [6:0] h;
    logic [7:0] by;
    n = len_of(t);
    h = {t, a};
    drive_bit(1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(h[i]);
    drive_bit((^h) ^ (flip == 0));
    for (int b = 0; b < n; b++) begin
      by = pay[31-8*b -: 8];
      for (int i = 7; i >= 0; i--) drive_bit(by[i]);
      drive_bit((^by) ^ (flip == b + 1));
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_has"},  rx_if.rx_has_data, m_has);
    chk({tag, "_type"}, rx_if.data_type,   m_type);
    chk({tag, "_addr"}, rx_if.address,     m_addr);
    chk({tag, "_bad"},  rx_if.bad_decode,  m_bad);
    chk({tag, "_pay"},  rx_if.rx_payload,  m_pay);
    chk({tag, "_cnt"},  rx_if.rx_byte_cnt, m_cnt);
  endtask

  // Full frame with an idle bit after it; rdy drives rc_ready in the completion cycle.
  task automatic do_frame(input string tag, input logic [2:0] t, input logic [3:0] a,
                          input logic [31:0] pay, input int flip, input logic rdy);
    int n;
    logic exp_ovr;
    logic [31:0] mp;
    drive_frame(t, a, pay, flip);
    @(negedge Clk_R);
    Rx_In = 1'b1;
    rx_if.rc_ready = rdy;
    chk({tag, "_has_before"}, rx_if.rx_has_data, m_has);
    n = len_of(t);
    mp = '0;
    for (int b = 0; b < n; b++) mp[31-8*b -: 8] = pay[31-8*b -: 8];
    exp_ovr = m_has && !rdy;
    if (!exp_ovr) begin
      m_has  = 1'b1;
      m_type = t;
      m_addr = a;
      m_bad  = !known(t) || (PAR_EN && flip >= 0 && flip <= n);
      m_pay  = mp;
      m_cnt  = 3'(n);
    end
    @(negedge Clk_R);
    rx_if.rc_ready = 1'b0;
    check_model(tag);
    chk({tag, "_ovr"}, rx_if.rx_overrun, exp_ovr);
  endtask

  task automatic pulse_ready(input string tag);
    rx_if.rc_ready = 1'b1;
    @(negedge Clk_R);
    rx_if.rc_ready = 1'b0;
    m_has = 1'b0;
    check_model(tag);
  endtask

  initial begin
    int o0;
    logic [2:0] rt;
    logic [6:0] h;

    vecs[0] = '{3'b111, 4'h1, 32'h0,        -1, 3'b111, 4'h1, 1'b0,   32'h0,        3'd0};
    vecs[1] = '{3'b001, 4'h5, 32'hA53CFF77, -1, 3'b001, 4'h5, 1'b0,   32'hA53CFF00, 3'd3};
    vecs[2] = '{3'b001, 4'h5, 32'hA53CFF00,  2, 3'b001, 4'h5, PAR_EN, 32'hA53CFF00, 3'd3};
    vecs[3] = '{3'b000, 4'hF, 32'h0,        -1, 3'b000, 4'hF, 1'b0,   32'h0,        3'd0};
    vecs[4] = '{3'b011, 4'hA, 32'h0,         0, 3'b011, 4'hA, PAR_EN, 32'h0,        3'd0};
    vecs[5] = '{3'b010, 4'h3, 32'hDEADBEEF, -1, 3'b010, 4'h3, 1'b0,   32'hDEADBEEF, 3'd4};
    vecs[6] = '{3'b101, 4'h6, 32'h0,        -1, 3'b101, 4'h6, 1'b1,   32'h0,        3'd0};
    vecs[7] = '{3'b110, 4'h0, 32'h11223344, -1, 3'b110, 4'h0, 1'b1,   32'h0,        3'd0};
    vecs[8] = '{3'b010, 4'h9, 32'h12345678,  4, 3'b010, 4'h9, PAR_EN, 32'h12345678, 3'd4};

    Rst_n = 1'b0;
    Rx_In = 1'b1;
    rx_if.rc_ready = 1'b0;
    m_has = 1'b0; m_type = '0; m_addr = '0; m_bad = 1'b0; m_pay = '0; m_cnt = '0;
    repeat (2) @(negedge Clk_R);
    check_model("reset");
    chk("reset_ovr", rx_if.rx_overrun, 1'b0);
    Rst_n = 1'b1;
    @(negedge Clk_R);

    // Vector table: each frame is latched, checked, then consumed.
    for (int i = 0; i < 9; i++) begin
      drive_frame(vecs[i].t, vecs[i].a, vecs[i].pay, vecs[i].flip);
      @(negedge Clk_R);
      Rx_In = 1'b1;
      chk($sformatf("vec%0d_latency", i), rx_if.rx_has_data, 1'b0);
      @(negedge Clk_R);
      chk($sformatf("vec%0d_has", i),  rx_if.rx_has_data, 1'b1);
      chk($sformatf("vec%0d_type", i), rx_if.data_type,   vecs[i].e_type);
      chk($sformatf("vec%0d_addr", i), rx_if.address,     vecs[i].e_addr);
      chk($sformatf("vec%0d_bad", i),  rx_if.bad_decode,  vecs[i].e_bad);
      chk($sformatf("vec%0d_pay", i),  rx_if.rx_payload,  vecs[i].e_pay);
      chk($sformatf("vec%0d_cnt", i),  rx_if.rx_byte_cnt, vecs[i].e_cnt);
      chk($sformatf("vec%0d_ovr", i),  rx_if.rx_overrun,  1'b0);
      rx_if.rc_ready = 1'b1;
      @(negedge Clk_R);
      rx_if.rc_ready = 1'b0;
      chk($sformatf("vec%0d_consumed", i), rx_if.rx_has_data, 1'b0);
      chk($sformatf("vec%0d_hold_type", i), rx_if.data_type, vecs[i].e_type);
      chk($sformatf("vec%0d_hold_addr", i), rx_if.address,   vecs[i].e_addr);
      m_type = vecs[i].e_type; m_addr = vecs[i].e_addr; m_bad = vecs[i].e_bad;
      m_pay = vecs[i].e_pay; m_cnt = vecs[i].e_cnt;
    end
    m_has = 1'b0;

    // Back-to-back ACKs without rc_ready: first held, second dropped.
    o0 = ovr_seen;
    drive_frame(3'b000, 4'h2, 32'h0, -1);
    drive_frame(3'b000, 4'h9, 32'h0, -1);
    @(negedge Clk_R);
    Rx_In = 1'b1;
    @(negedge Clk_R);
    chk("b2b_ovr_pulse", rx_if.rx_overrun, 1'b1);
    chk("b2b_has", rx_if.rx_has_data, 1'b1);
    chk("b2b_addr_first", rx_if.address, 4'h2);
    chk("b2b_type", rx_if.data_type, 3'b000);
    @(negedge Clk_R);
    chk("b2b_ovr_one_cycle", rx_if.rx_overrun, 1'b0);
    chk("b2b_ovr_count", 32'(ovr_seen - o0), 32'd1);
    m_has = 1'b1; m_type = 3'b000; m_addr = 4'h2; m_bad = 1'b0; m_pay = '0; m_cnt = '0;

    // Completion coinciding with rc_ready: new frame replaces the held one.
    do_frame("cmpl_rdy", 3'b111, 4'h4, 32'h0, -1, 1'b1);
    pulse_ready("clear");
    pulse_ready("ready_when_empty");

    // Random frames against the model.
    for (int k = 0; k < 30; k++) begin
      int fl;
      rt = 3'($urandom_range(0, 7));
      fl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len_of(rt))) : -1;
      do_frame($sformatf("rnd%0d", k), rt, 4'($urandom_range(0, 15)), $urandom(),
               fl, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) pulse_ready($sformatf("rnd%0d_rdy", k));
    end

    // Reset in the middle of a DATA_C payload while a frame is held.
    do_frame("pre_rst", 3'b010, 4'h7, 32'hCAFEF00D, -1, 1'b1);
    h = {3'b010, 4'h7};
    drive_bit(1'b0);
    for (int i = 6; i >= 0; i--) drive_bit(h[i]);
    drive_bit(^h);
    for (int i = 0; i < 5; i++) drive_bit(1'(i));
    @(negedge Clk_R);
    Rst_n = 1'b0;
    Rx_In = 1'b1;
    #1;
    m_has = 1'b0; m_type = '0; m_addr = '0; m_bad = 1'b0; m_pay = '0; m_cnt = '0;
    check_model("midrst");
    chk("midrst_ovr", rx_if.rx_overrun, 1'b0);
    @(negedge Clk_R);
    Rst_n = 1'b1;
    @(negedge Clk_R);
    do_frame("post_rst_token", 3'b111, 4'h1, 32'h0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
